// File: rtl/uart_cmd_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types for the UART command loader: opcode encoding taken from the
// low three bits of a header byte, and the loader state encoding.
// Optional feature macro: UART_CMD_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam int OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_INVALID = 3'd0,
      OP_WRITE_A = 3'd1,
      OP_WRITE_B = 3'd2,
      OP_SUM     = 3'd3,
      OP_AVG     = 3'd4,
      OP_EUC     = 3'd5,
      OP_MAN     = 3'd6,
      OP_READ    = 3'd7
   } opcode_e;

`ifdef UART_CMD_CHECKSUM_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2,
      CHECK  = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2
   } state_e;
`endif

endpackage

// File: rtl/uart_cmd_loader_rx_gap_timer.sv
// -----------------------------------------------------------------------------
// rx_gap_timer
// Counts idle cycles between received bytes while enabled. Asserts expired for
// one cycle when the count reaches TIMEOUT_CYCLES-1 without a clear. A clear in
// the same cycle suppresses expiry, so an arriving byte always wins.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   enable   in   count while high; counter held at 0 while low
//   clear    in   restart the count (a byte was received)
//   expired  out  timeout pulse
// -----------------------------------------------------------------------------
module rx_gap_timer #(
   parameter int TIMEOUT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   assign expired = enable && !clear && (count == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear || !enable || expired) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_loader.sv
// -----------------------------------------------------------------------------
// uart_cmd_loader
// Decodes one-byte command headers from the UART receiver. WRITE_A / WRITE_B
// stream N_ELEMS payload bytes into vector memory A or B; opcodes 3..7 are
// forwarded to the processing core as a single-cycle request. A load aborts
// with err_flag if the gap between payload bytes reaches TIMEOUT_CYCLES.
// Optional feature macro: UART_CMD_CHECKSUM_EN -- after the payload, one more
// byte must equal the XOR of all payload bytes before load_done is given.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_data, rx_ready     received byte and its single-cycle strobe
//   core_busy             core cannot accept a compute command
//   wr_en_a, wr_en_b      write strobes for vector memories A and B
//   wr_addr, wr_data      element address and value
//   cmd_valid, cmd_op     single-cycle compute request and its opcode
//   load_done             pulse after a completed load
//   err_flag              sticky error, cleared by the next accepted command
//   loading               high while in LOAD_A or LOAD_B
// -----------------------------------------------------------------------------
module uart_cmd_loader
   import uart_cmd_pkg::*;
#(
   parameter int N_ELEMS        = 1024,
   parameter int ADDR_W         = $clog2(N_ELEMS),
   parameter int TIMEOUT_CYCLES = 10_000_000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          rx_data,
   input  logic                rx_ready,
   input  logic                core_busy,
   output logic                wr_en_a,
   output logic                wr_en_b,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [7:0]          wr_data,
   output logic                cmd_valid,
   output logic [OPCODE_W-1:0] cmd_op,
   output logic                load_done,
   output logic                err_flag,
   output logic                loading
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEMS - 1);

   state_e            state;
   logic [ADDR_W-1:0] elem_cnt;
   logic              done_pend;   // delays load_done one cycle behind the final write
   logic              timed_out;
   opcode_e           rx_op;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]        xsum;
`endif

   assign rx_op = opcode_e'(rx_data[OPCODE_W-1:0]);

   rx_gap_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (state != IDLE),
      .clear   (rx_ready),
      .expired (timed_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         elem_cnt  <= '0;
         done_pend <= 1'b0;
         wr_en_a   <= 1'b0;
         wr_en_b   <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cmd_valid <= 1'b0;
         cmd_op    <= '0;
         load_done <= 1'b0;
         err_flag  <= 1'b0;
         loading   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         xsum      <= '0;
`endif
      end else begin
         // strobes default low; load_done trails the final write by one cycle
         wr_en_a   <= 1'b0;
         wr_en_b   <= 1'b0;
         cmd_valid <= 1'b0;
         load_done <= done_pend;
         done_pend <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_ready) begin
                  case (rx_op)
                     OP_INVALID: err_flag <= 1'b1;
                     OP_WRITE_A, OP_WRITE_B: begin
                        state    <= (rx_op == OP_WRITE_A) ? LOAD_A : LOAD_B;
                        elem_cnt <= '0;
                        err_flag <= 1'b0;
                        loading  <= 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                        xsum     <= '0;
`endif
                     end
                     default: begin
                        if (core_busy) begin
                           err_flag <= 1'b1;
                        end else begin
                           cmd_valid <= 1'b1;
                           cmd_op    <= rx_data[OPCODE_W-1:0];
                           err_flag  <= 1'b0;
                        end
                     end
                  endcase
               end
            end

            LOAD_A, LOAD_B: begin
               // every byte here is payload, whatever it looks like
               if (rx_ready) begin
                  wr_en_a  <= (state == LOAD_A);
                  wr_en_b  <= (state == LOAD_B);
                  wr_addr  <= elem_cnt;
                  wr_data  <= rx_data;
                  elem_cnt <= elem_cnt + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                  xsum     <= xsum ^ rx_data;
`endif
                  if (elem_cnt == LAST_IDX) begin
                     loading <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
                     state   <= CHECK;
`else
                     state     <= IDLE;
                     done_pend <= 1'b1;
`endif
                  end
               end else if (timed_out) begin
                  err_flag <= 1'b1;
                  loading  <= 1'b0;
                  state    <= IDLE;
               end
            end

`ifdef UART_CMD_CHECKSUM_EN
            CHECK: begin
               if (rx_ready) begin
                  state <= IDLE;
                  if (rx_data == xsum) begin
                     load_done <= 1'b1;
                  end else begin
                     err_flag <= 1'b1;
                  end
               end else if (timed_out) begin
                  err_flag <= 1'b1;
                  state    <= IDLE;
               end
            end
`endif

            default: begin
               state   <= IDLE;
               loading <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_loader
// Self-checking bench for uart_cmd_loader with N_ELEMS=4, TIMEOUT_CYCLES=100.
// A negedge monitor logs every memory write, compute request and load_done;
// each scenario compares those logs with what the command rules predict.
// Honours UART_CMD_CHECKSUM_EN by appending the XOR byte to every load.
// -----------------------------------------------------------------------------
module tb_uart_cmd_loader;

   localparam int N       = 4;
   localparam int AW      = 2;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic          b;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          core_busy;
   logic          wr_en_a, wr_en_b;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          cmd_valid;
   logic [2:0]    cmd_op;
   logic          load_done;
   logic          err_flag;
   logic          loading;

   int  pass_cnt  = 0;
   int  total_cnt = 0;
   wr_t wq[$];
   int  cq[$];
   int  done_cnt   = 0;
   int  excl_viol  = 0;

   always #5 clk = ~clk;

   uart_cmd_loader #(
      .N_ELEMS        (N),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .core_busy (core_busy),
      .wr_en_a   (wr_en_a),
      .wr_en_b   (wr_en_b),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .load_done (load_done),
      .err_flag  (err_flag),
      .loading   (loading)
   );

   always @(negedge clk) begin
      if (wr_en_a) wq.push_back('{b: 1'b0, addr: wr_addr, data: wr_data});
      if (wr_en_b) wq.push_back('{b: 1'b1, addr: wr_addr, data: wr_data});
      if (cmd_valid) cq.push_back(int'(cmd_op));
      if (load_done) done_cnt++;
      if ((wr_en_a && wr_en_b) || (cmd_valid && (wr_en_a || wr_en_b))) excl_viol++;
   end

   task automatic clear_logs();
      @(posedge clk);
      wq.delete();
      cq.delete();
      done_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   // header + payload (+ checksum byte when that feature is built in)
   task automatic do_load(input bit is_b, input logic [N-1:0][7:0] pl, input int gap_max);
      logic [7:0] x;
      x = 8'h00;
      send_byte({5'($urandom), is_b ? 3'd2 : 3'd1}, $urandom_range(1, 3));
      for (int i = 0; i < N; i++) begin
         send_byte(pl[i], $urandom_range(1, gap_max));
         x = x ^ pl[i];
      end
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(x, 1);
`endif
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      rx_ready  = 1'b0;
      rx_data   = 8'h00;
      core_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({wr_en_a, wr_en_b, cmd_valid, load_done, err_flag, loading} !== 6'b0)
         $display("FAIL reset_flags got %b want 000000",
                  {wr_en_a, wr_en_b, cmd_valid, load_done, err_flag, loading});
      else pass_cnt++;
      total_cnt++;
      if ({wr_addr, wr_data, cmd_op} !== '0)
         $display("FAIL reset_buses got addr=%0h data=%0h op=%0h want 0", wr_addr, wr_data, cmd_op);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_a();
      logic [N-1:0][7:0] pl;
      for (int it = 0; it < 3; it++) begin
         if (it == 0) pl = {8'h44, 8'h33, 8'h22, 8'h11};
         else         pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         clear_logs();
         do_load(1'b0, pl, 4);
         total_cnt++;
         if (wq.size() !== N) $display("FAIL write_a_count got %0d want %0d", wq.size(), N);
         else pass_cnt++;
         for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (wq[i] !== wr_t'{b: 1'b0, addr: AW'(i), data: pl[i]})
               $display("FAIL write_a_entry[%0d] got %h want %h", i, wq[i],
                        wr_t'{b: 1'b0, addr: AW'(i), data: pl[i]});
            else pass_cnt++;
         end
         total_cnt++;
         if (done_cnt !== 1) $display("FAIL write_a_done got %0d want 1", done_cnt);
         else pass_cnt++;
         total_cnt++;
         if (cq.size() !== 0 || err_flag !== 1'b0 || loading !== 1'b0)
            $display("FAIL write_a_side got cmds=%0d err=%b loading=%b want 0/0/0",
                     cq.size(), err_flag, loading);
         else pass_cnt++;
      end
   endtask

   task automatic test_write_b();
      logic [N-1:0][7:0] pl;
      for (int it = 0; it < 3; it++) begin
         // first pass: payload bytes that look like commands
         if (it == 0) pl = {8'h05, 8'h02, 8'h01, 8'h03};
         else         pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         clear_logs();
         do_load(1'b1, pl, 4);
         total_cnt++;
         if (wq.size() !== N) $display("FAIL write_b_count got %0d want %0d", wq.size(), N);
         else pass_cnt++;
         for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (wq[i] !== wr_t'{b: 1'b1, addr: AW'(i), data: pl[i]})
               $display("FAIL write_b_entry[%0d] got %h want %h", i, wq[i],
                        wr_t'{b: 1'b1, addr: AW'(i), data: pl[i]});
            else pass_cnt++;
         end
         total_cnt++;
         if (done_cnt !== 1 || cq.size() !== 0)
            $display("FAIL write_b_done got done=%0d cmds=%0d want 1/0", done_cnt, cq.size());
         else pass_cnt++;
      end
   endtask

   task automatic test_compute();
      int  op;
      bit  busy;
      bit  exp_err;
      for (int it = 0; it < 14; it++) begin
         // fixed opening sequence, then random headers
         if (it == 0)      begin op = 5; busy = 0; end
         else if (it == 1) begin op = 5; busy = 1; end
         else if (it == 2) begin op = 4; busy = 0; end
         else begin
            op = $urandom_range(0, 7);
            if (op == 1 || op == 2) op = 0;
            busy = 1'($urandom);
         end
         clear_logs();
         core_busy = busy;
         send_byte({5'($urandom), 3'(op)}, 3);
         core_busy = 1'($urandom);
         exp_err = (op == 0) || busy;
         total_cnt++;
         if (exp_err) begin
            if (cq.size() !== 0) $display("FAIL compute_drop op=%0d busy=%0d got %0d cmds want 0", op, busy, cq.size());
            else pass_cnt++;
         end else begin
            if (cq.size() !== 1 || cq[0] !== op)
               $display("FAIL compute_fwd got %0d cmds op=%0d want 1 op=%0d", cq.size(), cq[0], op);
            else pass_cnt++;
         end
         total_cnt++;
         if (err_flag !== exp_err) $display("FAIL compute_err op=%0d busy=%0d got %b want %b", op, busy, err_flag, exp_err);
         else pass_cnt++;
      end
      core_busy = 1'b0;
   endtask

   task automatic test_timeout();
      logic [N-1:0][7:0] pl;
      clear_logs();
      send_byte(8'h01, 2);
      send_byte(8'hAA, 1);
      repeat (150) @(negedge clk);
      total_cnt++;
      if (err_flag !== 1'b1 || loading !== 1'b0)
         $display("FAIL timeout_err got err=%b loading=%b want 1/0", err_flag, loading);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt !== 0 || wq.size() !== 1 || wq[0] !== wr_t'{b: 1'b0, addr: '0, data: 8'hAA})
         $display("FAIL timeout_partial got done=%0d writes=%0d first=%h want 0/1/0aa",
                  done_cnt, wq.size(), wq[0]);
      else pass_cnt++;
      clear_logs();
      send_byte(8'h06, 3);
      total_cnt++;
      if (cq.size() !== 1 || cq[0] !== 6 || err_flag !== 1'b0)
         $display("FAIL timeout_recover got cmds=%0d op=%0d err=%b want 1/6/0", cq.size(), cq[0], err_flag);
      else pass_cnt++;
      // gaps just short of the timeout must not abort the load
      pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      clear_logs();
      do_load(1'b0, pl, 90);
      total_cnt++;
      if (wq.size() !== N || done_cnt !== 1 || err_flag !== 1'b0)
         $display("FAIL slow_load got writes=%0d done=%0d err=%b want %0d/1/0", wq.size(), done_cnt, err_flag, N);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_load();
      logic [N-1:0][7:0] pl;
      send_byte(8'h01, 2);
      send_byte(8'h5A, 2);
      send_byte(8'hC3, 2);
      #3;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({wr_en_a, wr_en_b, cmd_valid, load_done, err_flag, loading} !== 6'b0 || wr_addr !== '0 || wr_data !== 8'h00)
         $display("FAIL async_reset got flags=%b addr=%0h data=%0h want 0",
                  {wr_en_a, wr_en_b, cmd_valid, load_done, err_flag, loading}, wr_addr, wr_data);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      clear_logs();
      do_load(1'b1, pl, 3);
      total_cnt++;
      if (wq.size() !== N || done_cnt !== 1) $display("FAIL post_reset_load got writes=%0d done=%0d want %0d/1", wq.size(), done_cnt, N);
      else pass_cnt++;
      for (int i = 0; i < N; i++) begin
         total_cnt++;
         if (wq[i] !== wr_t'{b: 1'b1, addr: AW'(i), data: pl[i]})
            $display("FAIL post_reset_entry[%0d] got %h want %h", i, wq[i], wr_t'{b: 1'b1, addr: AW'(i), data: pl[i]});
         else pass_cnt++;
      end
   endtask

`ifdef UART_CMD_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] seq [6];
      for (int k = 0; k < 2; k++) begin
         seq = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, (k == 0) ? 8'h0F : 8'h0E};
         clear_logs();
         foreach (seq[i]) send_byte(seq[i], 2);
         repeat (3) @(negedge clk);
         total_cnt++;
         if (done_cnt !== ((k == 0) ? 1 : 0) || err_flag !== ((k == 0) ? 1'b0 : 1'b1))
            $display("FAIL checksum_%0d got done=%0d err=%b want %0d/%b", k, done_cnt, err_flag,
                     (k == 0) ? 1 : 0, (k == 0) ? 1'b0 : 1'b1);
         else pass_cnt++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_a();
      test_write_b();
      test_compute();
      test_timeout();
      test_reset_mid_load();
`ifdef UART_CMD_CHECKSUM_EN
      test_checksum();
`endif
      total_cnt++;
      if (excl_viol !== 0) $display("FAIL strobe_exclusive got %0d overlaps want 0", excl_viol);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
